gf2m_pow_engine: RTL and testbench
==================================

// Module: gf2m_pow_engine
// PURPOSE
//  Iterative exponentiation engine: y = x^E over GF(2^M), polynomial basis, runtime exponent.
//  Successor to the fixed-exponent power maps. It is generalised in field width, reduction
//  polynomial and exponent, and adds a valid/ready handshake.
//  Uses MSB-first square-and-multiply, one exponent bit per clock.
//  Sits between S-box datapath and key-schedule logic.
//  E = 2^M-2 gives field inversion.
// PARAMETERS
//  M     6        field degree (2..16)
//  POLY  7'h43    reduction polynomial, M+1 bits incl. x^M term (default x^6+x+1)
//  EW    M        exponent width in bits (1..2M)
// PORTS
//  clk        in   1   rising-edge clock
//  rst        in   1   asynchronous active-high reset
//  in_valid   in   1   operand present
//  in_ready   out  1   engine idle, can accept
//  in_x       in   M   base x (polynomial basis, bit i = coeff of a^i)
//  in_e       in   EW  exponent E (unsigned)
//  out_valid  out  1   result present
//  out_ready  in   1   consumer accepts result
//  out_y      out  M   x^E
//  busy       out  1   state != IDLE
// BEHAVIOUR
//  Clock and reset
//  - One clock. Reset is asynchronous and active-high.
//  - On rst: state=IDLE; in_ready=1; out_valid=0; out_y=0; busy=0; all internal regs cleared.
//  States
//  - IDLE: in_ready=1. On in_valid&in_ready, capture x_r<=in_x, e_r<=in_e, acc<=1, cnt<=EW-1,
//    then go to RUN.
//  - RUN: each cycle acc <= sq(acc) * (e_r[cnt] ? x_r : 1), reduced mod POLY.
//    sq and mul are combinational within the cycle. cnt decrements.
//    After the cycle with cnt==0, go to DONE with out_y<=new acc.
//  - DONE: out_valid=1, out_y stable. On out_ready, go to IDLE with out_valid<=0.
//  Handshakes
//  - Latency: operand accepted on edge T gives out_valid high after edge T+EW (EW RUN cycles).
//    Throughput is 1 result per EW+2 cycles with out_ready held high.
//  - in_ready=0 in RUN/DONE. in_valid is ignored there; operands are not queued.
//  - out_y and out_valid change only on the DONE entry edge and the DONE exit edge.
//  - out_y holds its last result in IDLE. Only out_valid qualifies it.
//  - No combinational path from in_* to out_*. in_ready depends on state only.
//  Arithmetic
//  - mul: carry-less M x M product (2M-1 bits), reduced by POLY, no conditional shortcuts.
//  - sq is mul(acc, acc) or an equivalent linear map; both must give identical results.
//  - E=0 gives 1, including x=0 (0^0 := 1).
//  - x=0 with E!=0 gives 0. x=1 gives 1 for all E.
//  - Exponents >= 2^M-1 need no reduction: the loop handles them naturally.
//  Boundary cases
//  - Reset mid-RUN/DONE aborts; the partial result is discarded and never shown on out_y.
//  - in_valid in the same cycle as a DONE->IDLE exit is not accepted.
//    It is accepted the next cycle (IDLE).
//  - out_ready high outside DONE has no effect.
// TESTING (M=6, POLY=7'h43, EW=6)
//  1. x=6'h02, E=13 -> out_y=6'h0A exactly 6 cycles after accept; in_ready low throughout.
//  2. x=6'h02, E=62 -> 6'h21 (inverse of alpha). Also x=6'h21, E=1 -> 6'h21.
//  3. E=0 with x=6'h00 -> 6'h01. x=6'h00, E=13 -> 6'h00. x=6'h02, E=63 -> 6'h01.
//  4. Hold out_ready=0 for 10 cycles in DONE -> out_valid and out_y stable.
//     Keep in_valid=1 with a new operand: not accepted until 1 cycle after out_ready.
//  5. Assert rst at RUN cycle 3 -> out_valid=0, in_ready=1 immediately (async).
//     Next op x=6'h03, E=2 gives 6'h05.
//  6. Exhaustive: all 64 x and all 64 E against a software model, with random
//     in_valid/out_ready gaps; every result is matched in order.

Source files
------------

// File: rtl/gf2m_pow_engine.sv
// Iterative x^E over GF(2^M), polynomial basis, MSB-first square-and-multiply.
// One exponent bit per clock, valid/ready handshake on both sides.
module gf2m_pow_engine #(
  parameter int unsigned M    = 6,
  parameter logic [M:0]  POLY = 7'h43,
  parameter int unsigned EW   = M
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [M-1:0]  in_x,
  input  logic [EW-1:0] in_e,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [M-1:0]  out_y,
  output logic          busy
);

  localparam int unsigned PW = 2 * M - 1;
  localparam int unsigned CW = (EW > 1) ? $clog2(EW) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state, state_n;
  logic [M-1:0]   x_r;
  logic [EW-1:0]  e_r;
  logic [M-1:0]   acc;
  logic [CW-1:0]  cnt;
  logic [M-1:0]   acc_step;

  // Carry-less product followed by bitwise reduction; masks instead of branches
  // keep the datapath free of data-dependent shortcuts.
  function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
    logic [PW-1:0] p;
    logic [PW-1:0] aw;
    logic [PW-1:0] pw;
    p  = '0;
    aw = PW'(a);
    pw = PW'(POLY);
    for (int unsigned i = 0; i < M; i++)
      p ^= (aw << i) & {PW{b[i]}};
    for (int unsigned k = PW - 1; k >= M; k--)
      p ^= (pw << (k - M)) & {PW{p[k]}};
    return p[M-1:0];
  endfunction

  assign acc_step = gf_mul(gf_mul(acc, acc), e_r[cnt] ? x_r : M'(1));

  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_n = RUN;
      end
      RUN: begin
        if (cnt == '0) state_n = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      x_r   <= '0;
      e_r   <= '0;
      acc   <= '0;
      cnt   <= '0;
      out_y <= '0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: begin
          if (in_valid) begin
            x_r <= in_x;
            e_r <= in_e;
            acc <= M'(1);
            cnt <= CW'(EW - 1);
          end
        end
        RUN: begin
          acc <= acc_step;
          cnt <= cnt - 1'b1;
          if (cnt == '0) out_y <= acc_step;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gf2m_pow_engine.sv
// Self-checking bench for gf2m_pow_engine (M=6, POLY=x^6+x+1, EW=6).
// Expected results are queued at operand acceptance and popped at result handshake.
module tb_gf2m_pow_engine;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] in_x;
  logic [5:0] in_e;
  logic       out_valid;
  logic       out_ready;
  logic [5:0] out_y;
  logic       busy;

  int checks   = 0;
  int failures = 0;
  int n_in     = 0;
  int n_out    = 0;
  bit rnd_ready = 1'b0;
  logic [5:0] sb[$];

  gf2m_pow_engine #(.M(6), .POLY(7'h43), .EW(6)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_e(in_e),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference: shift-and-add multiply with xtime reduction, power by repeated multiply.
  function automatic logic [5:0] ref_mul(input logic [5:0] a, input logic [5:0] b);
    logic [6:0] aa;
    logic [5:0] r;
    aa = {1'b0, a};
    r  = '0;
    for (int i = 0; i < 6; i++) begin
      if (b[i]) r ^= aa[5:0];
      aa = aa << 1;
      if (aa[6]) aa ^= 7'h43;
    end
    return r;
  endfunction

  function automatic logic [5:0] ref_pow(input logic [5:0] x, input logic [5:0] e);
    logic [5:0] r;
    r = 6'h01;
    for (int i = 0; i < int'(e); i++) r = ref_mul(r, x);
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL result_unexpected got=%h with empty scoreboard", out_y);
      end else begin
        logic [5:0] exp;
        exp = sb.pop_front();
        if (out_y !== exp) begin
          failures++;
          $display("FAIL result_order got=%h expected=%h", out_y, exp);
        end
      end
      n_out++;
    end
  end

  always @(posedge clk) begin
    if (rnd_ready) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [5:0] x, input logic [5:0] e, input logic [5:0] exp);
    bit acc;
    acc = 1'b0;
    @(posedge clk); #1;
    in_x = x; in_e = e; in_valid = 1'b1;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(exp);
        n_in++;
        acc = 1'b1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    checks++;
    if (!acc) begin
      failures++;
      $display("FAIL send_accept x=%h e=%h got=not_accepted expected=accepted", x, e);
    end
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 400 && sb.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL %s_drain pending=%0d expected=0", name, sb.size());
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; in_x = '0; in_e = '0; out_ready = 1'b1;
    #12;
    checks++;
    if ({in_ready, out_valid, busy, out_y} !== {1'b1, 1'b0, 1'b0, 6'h00}) begin
      failures++;
      $display("FAIL reset_state got=rdy%b vld%b busy%b y%h expected=rdy1 vld0 busy0 y00",
               in_ready, out_valid, busy, out_y);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_latency;
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_x = 6'h02; in_e = 6'd13; in_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL latency_accept in_ready=%b expected=1", in_ready);
    end
    sb.push_back(6'h0A); n_in++;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i <= 6; i++) begin
      @(negedge clk);
      checks++;
      if (i < 6) begin
        if ({out_valid, in_ready, busy} !== 3'b001) begin
          failures++;
          $display("FAIL latency_run cycle=%0d got=vld%b rdy%b busy%b expected=vld0 rdy0 busy1",
                   i, out_valid, in_ready, busy);
        end
      end else if ({out_valid, out_y} !== {1'b1, 6'h0A}) begin
        failures++;
        $display("FAIL latency_done got=vld%b y%h expected=vld1 y0a", out_valid, out_y);
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_drain("latency");
  endtask

  task automatic test_values;
    out_ready = 1'b1;
    send(6'h02, 6'd62, 6'h21);
    send(6'h21, 6'd1,  6'h21);
    send(6'h00, 6'd0,  6'h01);
    send(6'h00, 6'd13, 6'h00);
    send(6'h02, 6'd63, 6'h01);
    send(6'h01, 6'd37, 6'h01);
    send(6'h03, 6'd2,  6'h05);
    wait_drain("values");
  endtask

  task automatic test_hold;
    bit seen;
    out_ready = 1'b0;
    send(6'h02, 6'd13, 6'h0A);
    @(posedge clk); #1;
    in_x = 6'h03; in_e = 6'd2; in_valid = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      seen = out_valid;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL hold_reach_done got=no_out_valid expected=out_valid");
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if ({out_valid, in_ready, out_y} !== {1'b1, 1'b0, 6'h0A}) begin
        failures++;
        $display("FAIL hold_stable cycle=%0d got=vld%b rdy%b y%h expected=vld1 rdy0 y0a",
                 i, out_valid, in_ready, out_y);
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({out_valid, in_ready, busy} !== 3'b010) begin
      failures++;
      $display("FAIL hold_exit got=vld%b rdy%b busy%b expected=vld0 rdy1 busy0",
               out_valid, in_ready, busy);
    end
    sb.push_back(6'h05); n_in++;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL hold_accept_next busy=%b expected=1", busy);
    end
    wait_drain("hold");
  endtask

  task automatic test_reset_mid_run;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_x = 6'h02; in_e = 6'd13; in_valid = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, in_ready, busy, out_y} !== {1'b0, 1'b1, 1'b0, 6'h00}) begin
      failures++;
      $display("FAIL reset_mid_run got=vld%b rdy%b busy%b y%h expected=vld0 rdy1 busy0 y00",
               out_valid, in_ready, busy, out_y);
    end
    @(negedge clk); rst = 1'b0;
    send(6'h03, 6'd2, 6'h05);
    wait_drain("reset_mid_run");
  endtask

  task automatic test_exhaustive;
    rnd_ready = 1'b1;
    for (int x = 0; x < 64; x++) begin
      for (int e = 0; e < 64; e++) begin
        if ($urandom_range(0, 3) == 0) @(posedge clk);
        send(6'(x), 6'(e), ref_pow(6'(x), 6'(e)));
      end
    end
    rnd_ready = 1'b0;
    @(posedge clk); #2;
    out_ready = 1'b1;
    wait_drain("exhaustive");
    checks++;
    if (n_out !== n_in) begin
      failures++;
      $display("FAIL result_count got=%0d expected=%0d", n_out, n_in);
    end
  endtask

  initial begin
    test_reset;
    test_latency;
    test_values;
    test_hold;
    test_reset_mid_run;
    test_exhaustive;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
